beat_timing_gen: RTL and testbench
==================================

// Module: beat_timing_gen
// PURPOSE
//   Machine-cycle timing generator; the producing end of the w1/w2/w3/t3 handshake the hardwired
//   controller consumes. It emits one-hot beats W1->W2->W3, each split into phases T1,T2,T3.
//   It follows the controller's sequencing requests (short, long, stop) sampled at the end of every beat.
//   It resumes a stopped sequence on the panel start key (qd). Sits between the panel/clock source and cpu.
// PARAMETERS
//   PHASE_LEN  2  clk cycles per phase (T1/T2/T3); legal range 1..15
// PORTS
//   clk         in   1  system clock; all state changes on its rising edge
//   clr         in   1  synchronous, active-high reset
//   qd          in   1  start key level; its rising edge (re)starts beat sequencing
//   stop        in   1  controller: halt after the current beat
//   short       in   1  controller: current W1 is the last beat of the cycle
//   long        in   1  controller: append W3 after W2
//   w1,w2,w3    out  1  beat strobes, at most one high, each high for the whole beat
//   t1,t2,t3    out  1  phase strobes, at most one high, each high for PHASE_LEN clk
//   t3_end      out  1  one-clk pulse on the last clk of T3; controller flops update on it
//   run         out  1  1 while beats are being generated
// BEHAVIOUR
//   - Reset (clr=1 at a clk edge): run=0, w*=0, t*=0, t3_end=0, phase counter=0, resume beat=W1,
//     qd edge detector primed with the current qd. clr overrides every other input in the same cycle.
//   - States: IDLE, BEAT(b in {W1,W2,W3}, p in {T1,T2,T3}, cnt 0..PHASE_LEN-1).
//   - IDLE: outputs w*/t*=0, run=0. A qd rising edge (qd=1 while the registered qd_d=0) goes to
//     BEAT(resume,T1,0) on the next clk. A qd level held high does not retrigger.
//   - BEAT: cnt increments each clk; at cnt=PHASE_LEN-1, p advances T1->T2->T3.
//     t3_end=1 while p=T3 && cnt=PHASE_LEN-1. Beat and phase outputs are registered (no glitches).
//   - Next beat is chosen on the t3_end clk from stop/short/long sampled in that same clk.
//     Priority is stop > short/long:
//       W1: short -> W1, else W2
//       W2: long  -> W3, else W1
//       W3: W1
//     short is ignored outside W1; long is ignored outside W2.
//   - stop=1 on t3_end: store the chosen next beat as resume and enter IDLE (w*=0 from next clk).
//     The next qd edge continues with resume; e.g. stop in W1 with short=0 resumes at W2.
//   - A qd edge while run=1 is ignored, but qd_d still tracks qd.
//   - Reset mid-beat: drops all strobes on the next clk; no t3_end is generated for the aborted beat.
//   - Latency: qd edge at clk n -> run=1, w=resume, t1=1 at clk n+1.
//     Beat length = 3*PHASE_LEN clk. Beat transitions have no gap cycles.
// TESTING
//   1. clr=1 two clk, qd=0 -> run=0 and all w*/t*/t3_end=0; holding qd=1 through reset then
//      releasing clr gives no start.
//   2. PHASE_LEN=2; qd edge, stop/short/long=0 -> sequence W1,W2,W1,W2 with each beat 6 clk,
//      t1/t2/t3 each 2 clk, t3_end on clk 6,12.
//   3. long=1 only during W2 -> W1,W2,W3,W1; with short=1 in W1 -> W1,W1; with long=1 in W1 ->
//      W1 is followed by W2 (long ignored).
//   4. stop=1 and short=1 at W1 t3_end -> IDLE, resume=W1. With stop=1, short=0 -> IDLE; the next
//      qd edge starts at W2,T1 one clk later.
//   5. qd toggled repeatedly while run=1 -> no effect on the sequence. qd held high across a
//      stop -> no restart until qd falls and rises again.
//   6. clr=1 mid-W2 T2 -> next clk all strobes 0, run=0; the following qd edge starts at W1.

Source files
------------

// File: rtl/beat_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : beat_timing_gen
// Description : Machine-cycle timing generator. Emits one-hot beats W1/W2/W3,
//               each split into phases T1/T2/T3 of PHASE_LEN clocks, steered
//               by the controller's stop/short/long requests and restarted by
//               the panel start key.
// Revision    : 1.0 - initial release
// ============================================================================
module beat_timing_gen #(
    parameter int PHASE_LEN = 2
) (
    input  logic clk,
    input  logic clr,
    input  logic qd,
    input  logic stop,
    input  logic short,
    input  logic long,
    output logic w1,
    output logic w2,
    output logic w3,
    output logic t1,
    output logic t2,
    output logic t3,
    output logic t3_end,
    output logic run
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BEAT = 1'b1
    } state_t;

    typedef enum logic [1:0] {
        BEAT_W1 = 2'd0,
        BEAT_W2 = 2'd1,
        BEAT_W3 = 2'd2
    } beat_t;

    typedef enum logic [1:0] {
        PH_T1 = 2'd0,
        PH_T2 = 2'd1,
        PH_T3 = 2'd2
    } phase_t;

    localparam logic [3:0] C_CNT_LAST = 4'(PHASE_LEN - 1);

    state_t     r_state;
    beat_t      r_beat;
    phase_t     r_phase;
    logic [3:0] r_cnt;
    beat_t      r_resume;
    logic       r_qd_d;

    logic       r_w1;
    logic       r_w2;
    logic       r_w3;
    logic       r_t1;
    logic       r_t2;
    logic       r_t3;
    logic       r_t3_end;
    logic       r_run;

    state_t     w_state_nxt;
    beat_t      w_beat_nxt;
    phase_t     w_phase_nxt;
    logic [3:0] w_cnt_nxt;
    beat_t      w_resume_nxt;
    beat_t      w_beat_after;
    logic       w_qd_rise;
    logic       w_cnt_last;
    logic       w_run_nxt;

    assign w_qd_rise  = qd & ~r_qd_d;
    assign w_cnt_last = (r_cnt == C_CNT_LAST);

    // Successor beat if the controller does not request a stop.
    always_comb begin
        w_beat_after = BEAT_W1;
        case (r_beat)
            BEAT_W1: w_beat_after = short ? BEAT_W1 : BEAT_W2;
            BEAT_W2: w_beat_after = long  ? BEAT_W3 : BEAT_W1;
            default: w_beat_after = BEAT_W1;
        endcase
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_beat_nxt   = r_beat;
        w_phase_nxt  = r_phase;
        w_cnt_nxt    = r_cnt;
        w_resume_nxt = r_resume;
        case (r_state)
            ST_IDLE: begin
                if (w_qd_rise) begin
                    w_state_nxt = ST_BEAT;
                    w_beat_nxt  = r_resume;
                    w_phase_nxt = PH_T1;
                    w_cnt_nxt   = 4'd0;
                end
            end
            ST_BEAT: begin
                if (w_cnt_last) begin
                    w_cnt_nxt = 4'd0;
                    case (r_phase)
                        PH_T1: w_phase_nxt = PH_T2;
                        PH_T2: w_phase_nxt = PH_T3;
                        default: begin
                            w_phase_nxt = PH_T1;
                            if (stop) begin
                                w_state_nxt  = ST_IDLE;
                                w_resume_nxt = w_beat_after;
                            end else begin
                                w_beat_nxt = w_beat_after;
                            end
                        end
                    endcase
                end else begin
                    w_cnt_nxt = r_cnt + 4'd1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign w_run_nxt = (w_state_nxt == ST_BEAT);

    always_ff @(posedge clk) begin
        if (clr) begin
            r_state  <= ST_IDLE;
            r_beat   <= BEAT_W1;
            r_phase  <= PH_T1;
            r_cnt    <= 4'd0;
            r_resume <= BEAT_W1;
            r_qd_d   <= qd;
        end else begin
            r_state  <= w_state_nxt;
            r_beat   <= w_beat_nxt;
            r_phase  <= w_phase_nxt;
            r_cnt    <= w_cnt_nxt;
            r_resume <= w_resume_nxt;
            r_qd_d   <= qd;
        end
    end

    // Strobes are decoded from the next state and registered so they are glitch-free.
    always_ff @(posedge clk) begin
        if (clr) begin
            r_run    <= 1'b0;
            r_w1     <= 1'b0;
            r_w2     <= 1'b0;
            r_w3     <= 1'b0;
            r_t1     <= 1'b0;
            r_t2     <= 1'b0;
            r_t3     <= 1'b0;
            r_t3_end <= 1'b0;
        end else begin
            r_run    <= w_run_nxt;
            r_w1     <= w_run_nxt && (w_beat_nxt == BEAT_W1);
            r_w2     <= w_run_nxt && (w_beat_nxt == BEAT_W2);
            r_w3     <= w_run_nxt && (w_beat_nxt == BEAT_W3);
            r_t1     <= w_run_nxt && (w_phase_nxt == PH_T1);
            r_t2     <= w_run_nxt && (w_phase_nxt == PH_T2);
            r_t3     <= w_run_nxt && (w_phase_nxt == PH_T3);
            r_t3_end <= w_run_nxt && (w_phase_nxt == PH_T3) && (w_cnt_nxt == C_CNT_LAST);
        end
    end

    assign run    = r_run;
    assign w1     = r_w1;
    assign w2     = r_w2;
    assign w3     = r_w3;
    assign t1     = r_t1;
    assign t2     = r_t2;
    assign t3     = r_t3;
    assign t3_end = r_t3_end;

endmodule
`default_nettype wire

// File: tb/tb_beat_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_beat_timing_gen
// Description : Directed bench for beat_timing_gen with PHASE_LEN = 2.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_beat_timing_gen;

    logic clk;
    logic clr;
    logic qd;
    logic stop;
    logic short;
    logic long;
    logic w1, w2, w3, t1, t2, t3, t3_end, run;

    int n_checks;
    int n_fail;

    beat_timing_gen #(.PHASE_LEN(2)) dut (
        .clk    (clk),
        .clr    (clr),
        .qd     (qd),
        .stop   (stop),
        .short  (short),
        .long   (long),
        .w1     (w1),
        .w2     (w2),
        .w3     (w3),
        .t1     (t1),
        .t2     (t2),
        .t3     (t3),
        .t3_end (t3_end),
        .run    (run)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Packed view: {run, w1, w2, w3, t1, t2, t3, t3_end}
    function automatic logic [7:0] obs();
        return {run, w1, w2, w3, t1, t2, t3, t3_end};
    endfunction

    task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%b exp=%b", tag, got, exp);
        end
    endtask

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Check ncyc cycles of beat b (1..3) from its first clock, holding the given controls.
    task automatic beat(input string tag, input int b, input logic s_stop,
                        input logic s_short, input logic s_long, input bit tgl, input int ncyc);
        logic [7:0] exp;
        stop  = s_stop;
        short = s_short;
        long  = s_long;
        for (int c = 0; c < ncyc; c++) begin
            exp = {1'b1, b == 1, b == 2, b == 3, c / 2 == 0, c / 2 == 1, c / 2 == 2, c == 5};
            check($sformatf("%s_c%0d", tag, c), obs(), exp);
            if (tgl) qd = ~qd;
            if (c != ncyc - 1) tick();
        end
        if (ncyc == 6) tick();
        stop  = 1'b0;
        short = 1'b0;
        long  = 1'b0;
    endtask

    task automatic start_edge();
        qd = 1'b0;
        tick();
        qd = 1'b1;
        tick();
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;
        clr   = 1'b1;
        qd    = 1'b0;
        stop  = 1'b0;
        short = 1'b0;
        long  = 1'b0;

        // Reset state, then qd held high through reset must not start.
        tick();
        tick();
        check("reset", obs(), 8'h00);
        qd = 1'b1;
        tick();
        clr = 1'b0;
        tick();
        tick();
        check("qd_held_thru_reset", obs(), 8'h00);

        // Free-running W1,W2,W1,W2 then stop at end of W2 (resume W1).
        start_edge();
        beat("seq_w1a", 1, 1'b0, 1'b0, 1'b0, 1'b0, 6);
        beat("seq_w2a", 2, 1'b0, 1'b0, 1'b0, 1'b0, 6);
        beat("seq_w1b", 1, 1'b0, 1'b0, 1'b0, 1'b0, 6);
        beat("seq_w2b", 2, 1'b1, 1'b0, 1'b0, 1'b0, 6);
        check("stop_w2_idle", obs(), 8'h00);

        // long ignored in W1, honoured in W2; short repeats W1; stop beats short.
        start_edge();
        beat("long_in_w1", 1, 1'b0, 1'b0, 1'b1, 1'b0, 6);
        beat("long_in_w2", 2, 1'b0, 1'b0, 1'b1, 1'b0, 6);
        beat("w3",         3, 1'b0, 1'b1, 1'b1, 1'b0, 6);
        beat("short_w1",   1, 1'b0, 1'b1, 1'b0, 1'b0, 6);
        beat("w1_again",   1, 1'b1, 1'b1, 1'b0, 1'b0, 6);
        check("stop_short_idle", obs(), 8'h00);
        start_edge();
        beat("resume_w1", 1, 1'b1, 1'b0, 1'b0, 1'b0, 6);
        check("stop_w1_idle", obs(), 8'h00);

        // qd stays high across the stop: no restart until it falls and rises.
        tick();
        tick();
        check("qd_held_no_restart", obs(), 8'h00);
        start_edge();
        beat("resume_w2", 2, 1'b0, 1'b0, 1'b0, 1'b1, 6);
        beat("tgl_w1",    1, 1'b0, 1'b0, 1'b0, 1'b1, 6);

        // Reset in W2/T2 kills strobes without a t3_end; restart from W1.
        beat("pre_clr_w2", 2, 1'b0, 1'b0, 1'b0, 1'b0, 3);
        clr = 1'b1;
        tick();
        check("clr_mid_beat", obs(), 8'h00);
        qd  = 1'b0;
        clr = 1'b0;
        tick();
        check("after_clr_idle", obs(), 8'h00);
        qd = 1'b1;
        tick();
        beat("post_clr_w1", 1, 1'b0, 1'b0, 1'b0, 1'b0, 6);
        beat("post_clr_w2", 2, 1'b1, 1'b0, 1'b0, 1'b0, 6);
        check("final_idle", obs(), 8'h00);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
